// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: buffers bytes from the uart receiver in a FIFO, optionally
// transforms them and replays them to the uart transmitter one at a time.
// Handshake with the transmitter: a byte is launched by a one-cycle `transmit`
// pulse with `tx_byte` already valid; the launch is complete only after
// `is_transmitting` has been seen high and then low again, and no new pulse is
// issued before that. `tx_byte` is held stable for the whole byte.
`timescale 1ns/1ps
module uart_echo_buffer #(
   parameter int DEPTH = 16,
   parameter int MODE  = 0,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     received,
   input  logic [7:0]               rx_byte,
   input  logic                     recv_error,
   input  logic                     is_transmitting,
   output logic                     transmit,
   output logic [7:0]               tx_byte,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_count,
   output logic [CNT_W-1:0]         err_count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_START,
      S_WAIT_DONE,
      S_LF
   } state_t;

   state_t           r_state;
   logic [7:0]       r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_fill;
   logic             r_transmit;
   logic [7:0]       r_tx_byte;
   logic             r_lf_sent;
   logic             r_overflow;
   logic [CNT_W-1:0] r_drop_count;
   logic [CNT_W-1:0] r_err_count;

   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [7:0]       w_head;

   // MODE 1 upper-cases ASCII letters; the other modes pass bytes through.
   function automatic logic [7:0] f_transform(input logic [7:0] b);
      if (MODE == 1 && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
      return b;
   endfunction

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_full = (r_fill == (AW+1)'(DEPTH));
   assign w_pop  = (r_state == S_IDLE) && (r_fill != '0);
   assign w_push = received && !recv_error && (!w_full || w_pop);
   assign w_drop = received && !recv_error && !w_push;
   assign w_head = r_mem[r_rptr];

   // Byte storage; contents need no reset because occupancy gates reads.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= rx_byte;
   end

   // Pointers wrap naturally at DEPTH (power of two); fill tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fill <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   // Sticky overflow flag and saturating drop / framing-error counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
         r_err_count  <= '0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
         end
         if (recv_error && r_err_count != '1) r_err_count <= r_err_count + 1'b1;
      end
   end

   // Transmit sequencer: launch one byte, wait for the uart to start and
   // finish it, and in MODE 2 follow a CR with a single inserted LF.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_transmit <= 1'b0;
         r_tx_byte  <= 8'h00;
         r_lf_sent  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_transmit <= 1'b0;
               if (w_pop) begin
                  r_tx_byte  <= f_transform(w_head);
                  r_transmit <= 1'b1;
                  r_lf_sent  <= 1'b0;
                  r_state    <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_transmit <= 1'b0;
               r_state    <= S_WAIT_START;
            end
            S_WAIT_START: begin
               if (is_transmitting) r_state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (!is_transmitting) begin
                  if (MODE == 2 && r_tx_byte == 8'h0D && !r_lf_sent)
                     r_state <= S_LF;
                  else
                     r_state <= S_IDLE;
               end
            end
            S_LF: begin
               r_tx_byte  <= 8'h0A;
               r_transmit <= 1'b1;
               r_lf_sent  <= 1'b1;
               r_state    <= S_LAUNCH;
            end
            default: begin
               r_transmit <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign transmit   = r_transmit;
   assign tx_byte    = r_tx_byte;
   assign fill       = r_fill;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;
   assign err_count  = r_err_count;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer: three instances (DEPTH 4 / MODE 0, DEPTH 16 /
// MODE 1, DEPTH 16 / MODE 2), each with a simple uart transmitter model and
// an expected-byte queue checked on every transmit pulse.
`timescale 1ns/1ps
module tb_uart_echo_buffer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       rcv0 = 0, rcv1 = 0, rcv2 = 0;
   logic [7:0] rxb0 = 0, rxb1 = 0, rxb2 = 0;
   logic       err0 = 0, err1 = 0, err2 = 0;
   logic       istx0, istx1, istx2;
   logic       tx0, tx1, tx2;
   logic [7:0] txb0, txb1, txb2;
   logic [2:0] fill0;
   logic [4:0] fill1, fill2;
   logic       ovf0, ovf1, ovf2;
   logic [7:0] drop0, drop1, drop2;
   logic [7:0] errc0, errc1, errc2;

   int busy0 = 5, busy1 = 5, busy2 = 5;
   int cnt0 = 0, cnt1 = 0, cnt2 = 0;
   int peak0 = 0;
   logic prev0 = 0, prev1 = 0, prev2 = 0;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   logic [7:0] exp_q2[$];

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   uart_echo_buffer #(.DEPTH(4), .MODE(0), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst(rst), .received(rcv0), .rx_byte(rxb0),
      .recv_error(err0), .is_transmitting(istx0), .transmit(tx0),
      .tx_byte(txb0), .fill(fill0), .overflow(ovf0),
      .drop_count(drop0), .err_count(errc0));

   uart_echo_buffer #(.DEPTH(16), .MODE(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .received(rcv1), .rx_byte(rxb1),
      .recv_error(err1), .is_transmitting(istx1), .transmit(tx1),
      .tx_byte(txb1), .fill(fill1), .overflow(ovf1),
      .drop_count(drop1), .err_count(errc1));

   uart_echo_buffer #(.DEPTH(16), .MODE(2), .CNT_W(8)) u_dut2 (
      .clk(clk), .rst(rst), .received(rcv2), .rx_byte(rxb2),
      .recv_error(err2), .is_transmitting(istx2), .transmit(tx2),
      .tx_byte(txb2), .fill(fill2), .overflow(ovf2),
      .drop_count(drop2), .err_count(errc2));

   // uart transmitter models: busy for busyN cycles after each pulse
   always @(posedge clk) begin
      if (tx0) cnt0 <= busy0; else if (cnt0 != 0) cnt0 <= cnt0 - 1;
      if (tx1) cnt1 <= busy1; else if (cnt1 != 0) cnt1 <= cnt1 - 1;
      if (tx2) cnt2 <= busy2; else if (cnt2 != 0) cnt2 <= cnt2 - 1;
   end
   assign istx0 = (cnt0 != 0);
   assign istx1 = (cnt1 != 0);
   assign istx2 = (cnt2 != 0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // scoreboards: sample on the falling edge, pop on every transmit pulse
   always @(negedge clk) begin
      if (rst) peak0 <= 0;
      else if (int'(fill0) > peak0) peak0 <= int'(fill0);
      if (tx0) begin
         check("dut0_pulse_width", 32'(prev0), 32'd0);
         check("dut0_tx_expected", 32'(exp_q0.size() != 0), 32'd1);
         if (exp_q0.size() != 0) check("dut0_tx_byte", 32'(txb0), 32'(exp_q0.pop_front()));
      end
      prev0 <= tx0;
   end

   always @(negedge clk) begin
      if (tx1) begin
         check("dut1_pulse_width", 32'(prev1), 32'd0);
         check("dut1_tx_expected", 32'(exp_q1.size() != 0), 32'd1);
         if (exp_q1.size() != 0) check("dut1_tx_byte", 32'(txb1), 32'(exp_q1.pop_front()));
      end
      prev1 <= tx1;
   end

   always @(negedge clk) begin
      if (tx2) begin
         check("dut2_pulse_width", 32'(prev2), 32'd0);
         check("dut2_waits_tx_idle", 32'(istx2), 32'd0);
         check("dut2_tx_expected", 32'(exp_q2.size() != 0), 32'd1);
         if (exp_q2.size() != 0) check("dut2_tx_byte", 32'(txb2), 32'(exp_q2.pop_front()));
      end
      prev2 <= tx2;
   end

   // driver tasks
   task automatic send(input int k, input logic [7:0] b, input logic e);
      @(posedge clk); #1;
      case (k)
         0: begin rcv0 = 1; rxb0 = b; err0 = e; end
         1: begin rcv1 = 1; rxb1 = b; err1 = e; end
         default: begin rcv2 = 1; rxb2 = b; err2 = e; end
      endcase
      @(posedge clk); #1;
      rcv0 = 0; rcv1 = 0; rcv2 = 0;
      err0 = 0; err1 = 0; err2 = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
   endtask

   task automatic wait_idle(input int k, input string tag);
      int n = 0;
      bit busy = 1;
      while (busy && n < 5000) begin
         case (k)
            0: busy = (exp_q0.size() != 0) || istx0 || (fill0 != 0);
            1: busy = (exp_q1.size() != 0) || istx1 || (fill1 != 0);
            default: busy = (exp_q2.size() != 0) || istx2 || (fill2 != 0);
         endcase
         if (busy) begin @(posedge clk); #1; n++; end
      end
      check(tag, 32'(n < 5000), 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // directed sequence
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      check("rst_transmit", 32'(tx0), 32'd0);
      check("rst_tx_byte", 32'(txb0), 32'h00);
      check("rst_fill", 32'(fill0), 32'd0);
      check("rst_overflow", 32'(ovf0), 32'd0);
      check("rst_drop_count", 32'(drop0), 32'd0);
      check("rst_err_count", 32'(errc0), 32'd0);

      // single byte latency
      exp_q0.push_back(8'h41);
      send(0, 8'h41, 1'b0);
      check("lat_fill_n1", 32'(fill0), 32'd1);
      check("lat_tx_n1", 32'(tx0), 32'd0);
      @(posedge clk); #1;
      check("lat_tx_n2", 32'(tx0), 32'd1);
      check("lat_byte_n2", 32'(txb0), 32'h41);
      check("lat_fill_n2", 32'(fill0), 32'd0);
      wait_idle(0, "single_done");
      check("tx_byte_held_idle", 32'(txb0), 32'h41);

      // burst into a 4-deep FIFO behind a slow transmitter
      busy0 = 100;
      for (int b = 1; b <= 5; b++) exp_q0.push_back(8'(b));
      for (int b = 1; b <= 6; b++) send(0, 8'(b), 1'b0);
      check("burst_overflow", 32'(ovf0), 32'd1);
      check("burst_drop_count", 32'(drop0), 32'd1);
      wait_idle(0, "burst_done");
      check("burst_fill_peak", 32'(peak0), 32'd4);
      busy0 = 5;

      // framing errors
      do_reset();
      check("reset_clears_overflow", 32'(ovf0), 32'd0);
      check("reset_clears_drop", 32'(drop0), 32'd0);
      send(0, 8'h55, 1'b1);
      check("err_count_1", 32'(errc0), 32'd1);
      check("err_not_pushed", 32'(fill0), 32'd0);
      check("err_no_overflow", 32'(ovf0), 32'd0);
      for (int i = 0; i < 254; i++) begin
         @(posedge clk); #1 err0 = 1;
         @(posedge clk); #1 err0 = 0;
      end
      check("err_count_255", 32'(errc0), 32'd255);
      for (int i = 0; i < 46; i++) begin
         @(posedge clk); #1 err0 = 1;
         @(posedge clk); #1 err0 = 0;
      end
      check("err_count_saturated", 32'(errc0), 32'd255);
      check("err_drop_unchanged", 32'(drop0), 32'd0);

      // reset while waiting for a byte to finish with 3 bytes queued
      busy0 = 50;
      exp_q0.push_back(8'hA1);
      send(0, 8'hA1, 1'b0);
      send(0, 8'hA2, 1'b0);
      send(0, 8'hA3, 1'b0);
      send(0, 8'hA4, 1'b0);
      check("midrst_fill_3", 32'(fill0), 32'd3);
      check("midrst_uart_busy", 32'(istx0), 32'd1);
      do_reset();
      check("midrst_fill", 32'(fill0), 32'd0);
      check("midrst_transmit", 32'(tx0), 32'd0);
      check("midrst_overflow", 32'(ovf0), 32'd0);
      check("midrst_err_count", 32'(errc0), 32'd0);
      busy0 = 5;
      exp_q0.push_back(8'hB5);
      send(0, 8'hB5, 1'b0);
      check("postrst_fill_n1", 32'(fill0), 32'd1);
      @(posedge clk); #1;
      check("postrst_tx_n2", 32'(tx0), 32'd1);
      check("postrst_byte_n2", 32'(txb0), 32'hB5);
      wait_idle(0, "postrst_done");

      // MODE 1 uppercase
      exp_q1.push_back(8'h41);
      exp_q1.push_back(8'h5A);
      exp_q1.push_back(8'h7B);
      exp_q1.push_back(8'h40);
      send(1, 8'h61, 1'b0);
      send(1, 8'h7A, 1'b0);
      send(1, 8'h7B, 1'b0);
      send(1, 8'h40, 1'b0);
      wait_idle(1, "mode1_done");

      // MODE 2 CR -> CR LF
      exp_q2.push_back(8'h0D);
      exp_q2.push_back(8'h0A);
      exp_q2.push_back(8'h41);
      send(2, 8'h0D, 1'b0);
      send(2, 8'h41, 1'b0);
      wait_idle(2, "mode2_done");
      check("mode2_tx_byte_held", 32'(txb2), 32'h41);

      check("q0_drained", 32'(exp_q0.size()), 32'd0);
      check("q1_drained", 32'(exp_q1.size()), 32'd0);
      check("q2_drained", 32'(exp_q2.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
